// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin sequencer sharing one AES master between requesters A and B.
// Latency: gnt 1 cycle after req, m_rst released RST_CYCLES later, rsp_valid 1 cycle after done.
// Backpressure: one job in flight, req held until gnt; AES_ARB_TIMEOUT_EN adds a RUN watchdog.
module aes_job_arbiter #(
    parameter int Nk             = 4,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic              clk_master,
    input  logic              rst,
    input  logic              req_a,
    input  logic              op_a,
    input  logic [127:0]      data_a,
    input  logic [Nk*32-1:0]  key_a,
    output logic              gnt_a,
    output logic              rsp_valid_a,
    input  logic              req_b,
    input  logic              op_b,
    input  logic [127:0]      data_b,
    input  logic [Nk*32-1:0]  key_b,
    output logic              gnt_b,
    output logic              rsp_valid_b,
    output logic [127:0]      rsp_data,
    output logic              busy,
    output logic              err_timeout,
    output logic              m_sel_encrypt,
    output logic              m_sel_decrypt,
    output logic              m_rst,
    output logic [127:0]      m_data_in,
    output logic [Nk*32-1:0]  m_key,
    input  logic              m_done_out,
    input  logic [127:0]      m_data_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
`ifdef AES_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             owner;    // 0 = A, 1 = B
    logic             prio_b;   // B wins a tie when set
    logic             pick_b;
    logic             pick_op;

    assign pick_b  = req_b & (~req_a | prio_b);
    assign pick_op = pick_b ? op_b : op_a;
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

`ifndef AES_ARB_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk_master) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            owner         <= 1'b0;
            prio_b        <= 1'b0;
            gnt_a         <= 1'b0;
            gnt_b         <= 1'b0;
            rsp_valid_a   <= 1'b0;
            rsp_valid_b   <= 1'b0;
            busy          <= 1'b0;
            m_sel_encrypt <= 1'b0;
            m_sel_decrypt <= 1'b0;
            m_rst         <= 1'b1;
            rsp_data      <= '0;
            m_data_in     <= '0;
            m_key         <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            err_timeout   <= 1'b0;
`endif
        end else begin
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            rsp_valid_a <= 1'b0;
            rsp_valid_b <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        owner         <= pick_b;
                        gnt_a         <= ~pick_b;
                        gnt_b         <= pick_b;
                        m_data_in     <= pick_b ? data_b : data_a;
                        m_key         <= pick_b ? key_b : key_a;
                        m_sel_encrypt <= ~pick_op;
                        m_sel_decrypt <= pick_op;
                        busy          <= 1'b1;
                        cnt           <= '0;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    // done from the master is meaningless while it is held in reset
                    if (cnt == RST_LAST) begin
                        m_rst <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RUN: begin
                    if (m_done_out) begin
                        rsp_data    <= m_data_out;
                        rsp_valid_a <= ~owner;
                        rsp_valid_b <= owner;
                        state       <= RESP;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        rsp_data    <= '0;
                        rsp_valid_a <= ~owner;
                        rsp_valid_b <= owner;
                        err_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt_inc;
                    end
`endif
                end
                RESP: begin
                    prio_b        <= ~owner;
                    busy          <= 1'b0;
                    m_sel_encrypt <= 1'b0;
                    m_sel_decrypt <= 1'b0;
                    m_rst         <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Randomised scoreboard bench for aes_job_arbiter with a behavioural stub AES master.
module tb_aes_job_arbiter;
    localparam int RST_CYC = 2;
    localparam int TO_CYC  = 16;
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk_master = 1'b0;
    logic rst = 1'b0;
    logic req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
    logic [127:0] data_a = '0, key_a = '0, data_b = '0, key_b = '0;
    logic gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, busy, err_timeout;
    logic m_sel_encrypt, m_sel_decrypt, m_rst;
    logic [127:0] rsp_data, m_data_in, m_key;
    logic m_done_out = 1'b0;
    logic [127:0] m_data_out = '0;

    aes_job_arbiter #(.Nk(4), .RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TO_CYC), .CNT_W(11)) dut (
        .clk_master(clk_master), .rst(rst),
        .req_a(req_a), .op_a(op_a), .data_a(data_a), .key_a(key_a), .gnt_a(gnt_a), .rsp_valid_a(rsp_valid_a),
        .req_b(req_b), .op_b(op_b), .data_b(data_b), .key_b(key_b), .gnt_b(gnt_b), .rsp_valid_b(rsp_valid_b),
        .rsp_data(rsp_data), .busy(busy), .err_timeout(err_timeout),
        .m_sel_encrypt(m_sel_encrypt), .m_sel_decrypt(m_sel_decrypt), .m_rst(m_rst),
        .m_data_in(m_data_in), .m_key(m_key), .m_done_out(m_done_out), .m_data_out(m_data_out));

    initial forever #5 clk_master = ~clk_master;

    typedef struct packed { logic [127:0] data; logic err; } exp_t;
    exp_t exp_q_a[$], exp_q_b[$];
    logic grant_log[$];

    int n_chk = 0, n_fail = 0;
    int n_issued = 0, n_dropped = 0, n_rsp = 0, cyc = 0;
    int stub_mode = 0;          // 0 random latency, 1 done held during LOAD, 2 never done
    logic stub_run_done = 1'b0;
    logic job_op [2];
    logic [127:0] job_data [2], job_key [2];

    // Stub master result: known AES vector, otherwise an invertible stand-in.
    function automatic logic [127:0] aes_ref(input logic op, input logic [127:0] d, input logic [127:0] k);
        if (!op && d == PT0 && k == KEY0) return CT0;
        if (op && d == CT0 && k == KEY0) return PT0;
        if (!op) return {d[63:0], d[127:64]} ^ k;
        return ~d ^ k;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive_req(input logic who, input logic r, input logic o, input logic [127:0] d, input logic [127:0] k);
        if (!who) begin req_a = r; op_a = o; data_a = d; key_a = k; end
        else      begin req_b = r; op_b = o; data_b = d; key_b = k; end
    endtask

    task automatic do_job(input logic who, input logic o, input logic [127:0] d, input logic [127:0] k,
                          input int gap, output int lat);
        bit got;
        exp_t e;
        repeat (gap) @(negedge clk_master);
        @(negedge clk_master);
        job_op[who] = o; job_data[who] = d; job_key[who] = k;
        drive_req(who, 1'b1, o, d, k);
        got = 0;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_master); #1;
            if ((who ? gnt_b : gnt_a) === 1'b1) begin got = 1; lat = i; break; end
        end
        chk("gnt_received", 128'(got), 128'(1));
        if (got) begin
            n_issued++;
            e.err  = (stub_mode == 2);
            e.data = (stub_mode == 2) ? '0 : aes_ref(o, d, k);
            if (!who) exp_q_a.push_back(e); else exp_q_b.push_back(e);
        end
        @(negedge clk_master);
        drive_req(who, 1'b0, 1'($urandom), rand128(), rand128());
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_master);
            if (busy === 1'b0) begin idle = 1; break; end
        end
        chk("idle_reached", 128'(idle), 128'(1));
        repeat (2) @(negedge clk_master);
    endtask

    // Stub AES master
    initial begin
        bit fired = 0;
        int wait_n = 0;
        forever begin
            @(negedge clk_master);
            m_data_out = rand128();
            if (m_rst !== 1'b0) begin
                m_done_out = (stub_mode == 1) && (busy === 1'b1);
                fired  = 0;
                wait_n = (stub_mode == 1) ? $urandom_range(1, 5) : $urandom_range(0, 5);
            end else if (fired || stub_mode == 2) begin
                m_done_out = 1'b0;
            end else if (wait_n == 0) begin
                m_done_out = 1'b1;
                fired = 1;
                stub_run_done = 1'b1;
                if (m_sel_encrypt && !m_sel_decrypt)      m_data_out = aes_ref(1'b0, m_data_in, m_key);
                else if (!m_sel_encrypt && m_sel_decrypt) m_data_out = aes_ref(1'b1, m_data_in, m_key);
                else                                      m_data_out = '0;
            end else begin
                wait_n--;
                m_done_out = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic out = 0, owner = 0, last_b = 1, prev_mrst = 1, expw, cur_op = 0;
        logic [127:0] cur_data = '0, cur_key = '0, last_rsp = '0;
        int gnt_cyc = 0, run_cyc = 0, ng, nr;
        bit have;
        exp_t e;
        forever begin
            @(posedge clk_master); #1;
            cyc++;
            if (rst !== 1'b1) begin
                chk("rst_gnt", 128'({gnt_a, gnt_b}), 128'(0));
                chk("rst_rsp_valid", 128'({rsp_valid_a, rsp_valid_b}), 128'(0));
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_err_timeout", 128'(err_timeout), 128'(0));
                chk("rst_sel", 128'({m_sel_encrypt, m_sel_decrypt}), 128'(0));
                chk("rst_m_rst", 128'(m_rst), 128'(1));
                chk("rst_rsp_data", rsp_data, '0);
                chk("rst_m_data_in", m_data_in, '0);
                chk("rst_m_key", m_key, '0);
                out = 0; last_b = 1; prev_mrst = 1; last_rsp = '0;
                exp_q_a.delete(); exp_q_b.delete();
                stub_run_done = 1'b0;
            end else begin
                ng = int'(gnt_a) + int'(gnt_b);
                if (ng != 0) begin
                    chk("single_gnt", 128'(ng), 128'(1));
                    chk("gnt_only_when_idle", 128'(out), 128'(0));
                    chk("gnt_has_req", 128'(req_a | req_b), 128'(1));
                    expw = (req_a && req_b) ? !last_b : req_b;
                    chk("arb_winner", 128'(gnt_b), 128'(expw));
                    owner = gnt_b;
                    grant_log.push_back(owner);
                    cur_op = job_op[owner]; cur_data = job_data[owner]; cur_key = job_key[owner];
                    gnt_cyc = cyc;
                    out = 1;
                end
                chk("busy", 128'(busy), 128'(out));
                chk("sel_onehot", 128'(m_sel_encrypt & m_sel_decrypt), 128'(0));
                if (!out) begin
                    chk("idle_m_rst", 128'(m_rst), 128'(1));
                    chk("idle_sel", 128'({m_sel_encrypt, m_sel_decrypt}), 128'(0));
                end
                if (out && prev_mrst && !m_rst) begin
                    chk("m_rst_release_latency", 128'(cyc - gnt_cyc), 128'(RST_CYC));
                    chk("sel_encrypt", 128'(m_sel_encrypt), 128'(!cur_op));
                    chk("sel_decrypt", 128'(m_sel_decrypt), 128'(cur_op));
                    chk("m_data_in", m_data_in, cur_data);
                    chk("m_key", m_key, cur_key);
                    run_cyc = cyc;
                end
                nr = int'(rsp_valid_a) + int'(rsp_valid_b);
                if (nr != 0) begin
                    chk("single_rsp", 128'(nr), 128'(1));
                    chk("rsp_outstanding", 128'(out), 128'(1));
                    chk("rsp_owner", 128'(rsp_valid_b), 128'(owner));
                    have = rsp_valid_b ? (exp_q_b.size() != 0) : (exp_q_a.size() != 0);
                    chk("rsp_expected", 128'(have), 128'(1));
                    if (have) begin
                        e = rsp_valid_b ? exp_q_b.pop_front() : exp_q_a.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("err_timeout", 128'(err_timeout), 128'(e.err));
                        if (e.err) chk("timeout_run_cycles", 128'(cyc - run_cyc), 128'(TO_CYC));
                        else begin
                            chk("rsp_after_run_done", 128'(stub_run_done), 128'(1));
                            chk("done_to_rsp_latency", 128'(m_done_out), 128'(1));
                        end
                        last_rsp = e.data;
                    end
                    stub_run_done = 1'b0;
                    last_b = owner;
                    out = 0;
                    n_rsp++;
                end else begin
                    chk("err_timeout_quiet", 128'(err_timeout), 128'(0));
                    chk("rsp_data_hold", rsp_data, last_rsp);
                end
                prev_mrst = m_rst;
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, base, rsp_before;
        bit ran;
        repeat (3) @(negedge clk_master);
        rst = 1'b1;

        // Known-answer encrypt on A, decrypt on B
        do_job(1'b0, 1'b0, PT0, KEY0, 0, lat);
        chk("gnt_a_latency", 128'(lat), 128'(0));
        wait_idle();
        do_job(1'b1, 1'b1, CT0, KEY0, 0, lat);
        chk("gnt_b_latency", 128'(lat), 128'(0));
        wait_idle();

        // Simultaneous requests alternate A, B, A
        base = grant_log.size();
        fork
            for (int i = 0; i < 3; i++) begin int l; do_job(1'b0, 1'($urandom), rand128(), rand128(), 0, l); end
            for (int i = 0; i < 3; i++) begin int l; do_job(1'b1, 1'($urandom), rand128(), rand128(), 0, l); end
        join
        wait_idle();
        chk("rr_grant0", 128'(grant_log[base]), 128'(0));
        chk("rr_grant1", 128'(grant_log[base+1]), 128'(1));
        chk("rr_grant2", 128'(grant_log[base+2]), 128'(0));

        // Done asserted while master is still in reset must be ignored
        stub_mode = 1;
        for (int i = 0; i < 4; i++) begin
            do_job(1'($urandom), 1'($urandom), rand128(), rand128(), 0, lat);
            wait_idle();
        end
        stub_mode = 0;

        // Random traffic from both sides
        fork
            for (int i = 0; i < 15; i++) begin int l;
                do_job(1'b0, 1'($urandom), rand128(), ($urandom_range(0, 3) == 0) ? KEY0 : rand128(), $urandom_range(0, 4), l);
            end
            for (int i = 0; i < 15; i++) begin int l;
                do_job(1'b1, 1'($urandom), rand128(), rand128(), $urandom_range(0, 4), l);
            end
        join
        wait_idle();

        // Reset during RUN drops the job
        stub_mode = 2;
        rsp_before = n_rsp;
        do_job(1'b0, 1'b0, rand128(), rand128(), 0, lat);
        ran = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_master);
            if (m_rst === 1'b0) begin ran = 1; break; end
        end
        chk("reached_run", 128'(ran), 128'(1));
        repeat (3) @(negedge clk_master);
        rst = 1'b0;
        n_dropped++;
        @(negedge clk_master);
        rst = 1'b1;
        repeat (10) @(negedge clk_master);
        chk("no_rsp_after_reset", 128'(n_rsp), 128'(rsp_before));
        stub_mode = 0;
        base = grant_log.size();
        do_job(1'b1, 1'b1, rand128(), rand128(), 0, lat);
        chk("gnt_b_after_reset_latency", 128'(lat), 128'(0));
        wait_idle();
        chk("rsp_after_reset_job", 128'(n_rsp), 128'(rsp_before + 1));

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog abort, then B must win the next tie
        stub_mode = 2;
        rsp_before = n_rsp;
        do_job(1'b0, 1'b0, rand128(), rand128(), 0, lat);
        wait_idle();
        chk("timeout_rsp_count", 128'(n_rsp), 128'(rsp_before + 1));
        stub_mode = 0;
        base = grant_log.size();
        fork
            begin int l; do_job(1'b0, 1'($urandom), rand128(), rand128(), 0, l); end
            begin int l; do_job(1'b1, 1'($urandom), rand128(), rand128(), 0, l); end
        join
        wait_idle();
        chk("ptr_after_timeout", 128'(grant_log[base]), 128'(1));
`endif

        chk("exp_queues_empty", 128'(exp_q_a.size() + exp_q_b.size()), 128'(0));
        chk("rsp_count", 128'(n_rsp), 128'(n_issued - n_dropped));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
Sequencer and arbiter that shares one AES SPI `master` instance between two requesters, A and B. It accepts encrypt/decrypt jobs over a req/gnt handshake and grants them round-robin. For each job it restarts the master, drives the select lines, data and key, waits for done_out, and returns the 128-bit result with a one-cycle valid pulse to the owning requester. It sits directly above the `master` in the AES top level.

Parameters:
Nk, 4, key length in 32-bit words; key ports are Nk*32 bits wide.
RST_CYCLES, 2, number of cycles m_rst is held high at job start (minimum 1).
TIMEOUT_CYCLES, 1024, RUN-state watchdog limit; used only with AES_ARB_TIMEOUT_EN.
CNT_W, 11, counter width; must hold both RST_CYCLES and TIMEOUT_CYCLES.

Ports:
clk_master  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
req_a  in  1  job request from A; held until gnt_a.
op_a  in  1  0 = encrypt, 1 = decrypt.
data_a  in  128  input block from A.
key_a  in  Nk*32  key from A.
gnt_a  out  1  one-cycle pulse: A's job was latched.
rsp_valid_a  out  1  one-cycle pulse: rsp_data holds A's result.
req_b, op_b, data_b, key_b, gnt_b, rsp_valid_b  same as the A ports, for requester B.
rsp_data  out  128  result of the most recent job; shared by A and B.
busy  out  1  high from grant until the response cycle inclusive.
err_timeout  out  1  one-cycle pulse coincident with rsp_valid_x on a watchdog abort.
m_sel_encrypt  out  1  to master sel_encrypt.
m_sel_decrypt  out  1  to master sel_decrypt.
m_rst  out  1  to master rst (active-high).
m_data_in  out  128  to master data_in.
m_key  out  Nk*32  to master key.
m_done_out  in  1  from master done_out.
m_data_out  in  128  from master data_out.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, busy, err_timeout, m_sel_encrypt, m_sel_decrypt = 0.
  - rsp_data, m_data_in, m_key = 0.
  - m_rst = 1.
  - Round-robin pointer = "A has priority".
- Reset mid-job: the job is dropped, no response is issued, and the master is held in reset while rst=0.
- States: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - m_rst=1 and both selects are 0.
  - If req_a or req_b is sampled high, choose the winner:
    - one requester: that requester wins.
    - both: the requester not served last wins; A wins after reset.
  - On the choice: latch op/data/key into m_data_in/m_key/owner, pulse gnt_x for the next cycle, set busy, go to LOAD.
  - The requester may drop req or change inputs after gnt_x. A req dropped before gnt is a withdrawal.
- LOAD:
  - m_rst=1 for RST_CYCLES cycles.
  - Selects are driven: op=0 -> sel_encrypt=1, sel_decrypt=0; op=1 -> sel_encrypt=0, sel_decrypt=1. The selects are one-hot and never both 1.
  - m_done_out is ignored in this state.
  - Then go to RUN with m_rst=0.
- RUN:
  - m_rst=0; selects, m_data_in and m_key stay stable.
  - On the first cycle m_done_out=1: capture m_data_out into rsp_data, go to RESP.
- RESP:
  - rsp_valid_x=1 for exactly one cycle to the owner.
  - Toggle the pointer to the other requester, clear busy and the selects, set m_rst=1, return to IDLE.
  - No new grant is issued in the RESP cycle. The earliest next gnt is one cycle after RESP.
- Latency: req sampled at edge N -> gnt_x in cycle N+1 -> m_rst low from cycle N+1+RST_CYCLES. m_done_out seen at edge D -> rsp_valid_x in cycle D+1.
- rsp_data holds its value until the next capture.
- At most one job is outstanding; the block never queues.
- The counter does not wrap: it saturates at TIMEOUT_CYCLES.

Optional Feature:
Macro AES_ARB_TIMEOUT_EN.
- Defined: the counter runs in RUN. If it reaches TIMEOUT_CYCLES with m_done_out still 0:
  - go to RESP with rsp_data=0;
  - pulse err_timeout together with rsp_valid_x;
  - advance the pointer as usual.
- Not defined: RUN waits indefinitely, err_timeout is tied to 0, and no watchdog logic is synthesised.

Test Plan:
1. req_a=1, op_a=0, key_a=000102030405060708090a0b0c0d0e0f, data_a=00112233445566778899aabbccddeeff -> gnt_a one cycle later; m_sel_encrypt=1, m_sel_decrypt=0; rsp_valid_a pulses once with rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a; rsp_valid_b stays 0.
2. req_b=1, op_b=1, same key, data_b=69c4e0d86a7b0430d8cdb78070b4c55a -> m_sel_encrypt=0, m_sel_decrypt=1; rsp_valid_b pulses with rsp_data=00112233445566778899aabbccddeeff.
3. req_a and req_b asserted in the same cycle, three times back-to-back -> grants in order A, B, A; never two gnt pulses in one cycle; each rsp_valid goes to the matching owner.
4. rst=0 for one cycle during RUN of an A job -> no rsp_valid_a; m_rst=1 and all other outputs at their reset values on the next cycle; a fresh req_b is granted normally.
5. Stub master holding m_done_out=1 during LOAD, then 0 -> no early response; a done pulse in RUN produces exactly one rsp_valid one cycle later.
6. With AES_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, stub master never raises done -> after 16 RUN cycles, rsp_valid_a and err_timeout pulse together with rsp_data=0; the pointer now favours B.
